// File: rtl/my_div_if.sv
// Operand/result handshake bundle for the sequential fixed-point divider.
interface my_div_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] q;
    logic                  div_zero;
    logic                  ovf;

    // Operand source / result consumer side
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, q, div_zero, ovf
    );

    // Divider side
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, q, div_zero, ovf
    );
endinterface

// File: rtl/my_div.sv
// Sequential signed Q-format divider: radix-2 restoring, one quotient bit per clock,
// with sign restore, saturation and divide-by-zero flagging in a final cycle.
module my_div #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned INT_WIDTH  = 16
) (
    input  logic    clk,
    input  logic    rst,
    my_div_if.slave bus
);
    localparam int unsigned FRAC = DATA_WIDTH - INT_WIDTH;
    localparam int unsigned N    = DATA_WIDTH + FRAC;
    localparam int unsigned CW   = $clog2(N + 1);
    localparam int unsigned RW   = DATA_WIDTH + 1;

    localparam logic [DATA_WIDTH-1:0] Q_MIN = DATA_WIDTH'(1) << (DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] Q_MAX = ~Q_MIN;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [N-1:0]          dvd_r;
    logic [DATA_WIDTH-1:0] rem_r;
    logic [N-1:0]          quo_r;
    logic [DATA_WIDTH-1:0] dvs_r;
    logic                  sgn_r;
    logic                  zflag_r;
    logic [CW-1:0]         cnt_r;

    logic [DATA_WIDTH-1:0] abs_a_c;
    logic [DATA_WIDTH-1:0] abs_b_c;
    logic [RW-1:0]         rem_sh_c;
    logic                  ge_c;
    logic [DATA_WIDTH-1:0] rem_nx_c;
    logic [DATA_WIDTH-1:0] res_q_c;
    logic                  res_ovf_c;
    logic                  res_dz_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.in_valid)  state_nx = S_RUN;
            S_RUN:   if (cnt_r == '0)   state_nx = S_FIN;
            S_FIN:                      state_nx = S_DONE;
            S_DONE:  if (bus.out_ready) state_nx = S_IDLE;
            default:                    state_nx = S_IDLE;
        endcase
    end

    // Operand magnitudes; the most negative value maps to 2^(DW-1) as an unsigned pattern
    always_comb begin
        abs_a_c = bus.a[DATA_WIDTH-1] ? -bus.a : bus.a;
        abs_b_c = bus.b[DATA_WIDTH-1] ? -bus.b : bus.b;
    end

    // One restoring step: shift in the next dividend bit, subtract divisor if it fits
    always_comb begin
        rem_sh_c = {rem_r, dvd_r[N-1]};
        ge_c     = rem_sh_c >= {1'b0, dvs_r};
        rem_nx_c = ge_c ? (rem_sh_c[DATA_WIDTH-1:0] - dvs_r) : rem_sh_c[DATA_WIDTH-1:0];
    end

    // Result shaping: zero-divisor code, saturation, sign restore
    always_comb begin
        res_q_c   = quo_r[DATA_WIDTH-1:0];
        res_ovf_c = 1'b0;
        res_dz_c  = 1'b0;
        if (zflag_r) begin
            res_dz_c = 1'b1;
            res_q_c  = sgn_r ? Q_MIN : Q_MAX;
        end else if (!sgn_r) begin
            if (quo_r > N'(Q_MAX)) begin
                res_q_c   = Q_MAX;
                res_ovf_c = 1'b1;
            end
        end else begin
            if (quo_r > N'(Q_MIN)) begin
                res_q_c   = Q_MIN;
                res_ovf_c = 1'b1;
            end else begin
                res_q_c = -quo_r[DATA_WIDTH-1:0];
            end
        end
    end

    // Iteration datapath: operand capture in IDLE, shift/subtract in RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_r   <= '0;
            rem_r   <= '0;
            quo_r   <= '0;
            dvs_r   <= '0;
            sgn_r   <= 1'b0;
            zflag_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        dvd_r   <= N'(abs_a_c) << FRAC;
                        dvs_r   <= abs_b_c;
                        sgn_r   <= bus.a[DATA_WIDTH-1] ^ bus.b[DATA_WIDTH-1];
                        zflag_r <= (bus.b == '0);
                        rem_r   <= '0;
                        quo_r   <= '0;
                        cnt_r   <= CW'(N - 1);
                    end
                end
                S_RUN: begin
                    rem_r <= rem_nx_c;
                    dvd_r <= dvd_r << 1;
                    quo_r <= N'({quo_r, ge_c});
                    cnt_r <= cnt_r - CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.q         <= '0;
            bus.div_zero  <= 1'b0;
            bus.ovf       <= 1'b0;
        end else begin
            bus.in_ready  <= (state_nx == S_IDLE);
            bus.out_valid <= (state_nx == S_DONE);
            if (state == S_FIN) begin
                bus.q        <= res_q_c;
                bus.div_zero <= res_dz_c;
                bus.ovf      <= res_ovf_c;
            end
        end
    end
endmodule

// File: tb/tb_my_div.sv
// Self-checking bench for my_div in 16Q16: directed vectors, randomized operands
// against an arithmetic reference, back-to-back throughput, mid-run reset, result hold.
module tb_my_div;
    localparam int unsigned DW     = 32;
    localparam int unsigned IW     = 16;
    localparam int unsigned FRAC   = DW - IW;
    localparam int unsigned N      = DW + FRAC;
    localparam int          LAT    = N + 2;
    localparam int          PERIOD = N + 3;
    localparam int          TMO    = 200;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    my_div_if #(.DATA_WIDTH(DW)) bus ();

    my_div #(.DATA_WIDTH(DW), .INT_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: exact magnitude quotient in wide integers, then the result rules
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic dz, output logic ov);
        longint          sa, sb;
        longint unsigned ma, mb, mq;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ma = 64'((sa < 0) ? -sa : sa);
        mb = 64'((sb < 0) ? -sb : sb);
        dz = 1'b0;
        ov = 1'b0;
        if (b == 32'h0) begin
            dz = 1'b1;
            q  = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            mq = (ma << FRAC) / mb;
            if (a[31] == b[31]) begin
                if (mq > 64'h7FFF_FFFF) begin q = 32'h7FFF_FFFF; ov = 1'b1; end
                else                          q = 32'(mq);
            end else begin
                if (mq > 64'h8000_0000) begin q = 32'h8000_0000; ov = 1'b1; end
                else                          q = 32'(64'd0 - mq);
            end
        end
    endfunction

    // Drive one operation; hold the result 'stall' cycles, then take it
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int stall,
                          output logic [31:0] q, output logic dz, output logic ov, output int lat);
        int w;
        w = 0;
        q = '0; dz = 1'b0; ov = 1'b0; lat = TMO;
        bus.a = a; bus.b = b; bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && w < TMO) begin @(posedge clk); #1; w++; end
        if (w >= TMO) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready=%b required 1", bus.in_ready);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        lat = 1;
        // Garbage operands while busy must be ignored
        bus.a = $urandom; bus.b = $urandom;
        while (bus.out_valid !== 1'b1 && lat < TMO) begin @(posedge clk); #1; lat++; end
        bus.in_valid = 1'b0;
        if (lat >= TMO) begin
            checks++; errors++;
            $display("FAIL result_timeout: out_valid=%b required 1", bus.out_valid);
            return;
        end
        q = bus.q; dz = bus.div_zero; ov = bus.ovf;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.q !== q || bus.div_zero !== dz || bus.ovf !== ov) begin
                errors++;
                $display("FAIL hold cycle %0d: out_valid=%b q=%h got, required 1 q=%h", i, bus.out_valid, bus.q, q);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release: out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.a = 32'h0006_0000; bus.b = 32'h0002_0000; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.q !== 32'h0 ||
            bus.div_zero !== 1'b0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b q=%h dz=%b ovf=%b required 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.q, bus.div_zero, bus.ovf);
        end
        bus.in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: in_ready=%b required 1", bus.in_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [11] = '{32'h0006_0000, 32'h0001_0000, 32'hFFFF_0000, 32'hFFF9_0000,
                                 32'h0005_0000, 32'hFFFB_0000, 32'h7FFF_0000, 32'h8000_0000,
                                 32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] vb [11] = '{32'h0002_0000, 32'h0003_0000, 32'h0003_0000, 32'h0002_0000,
                                 32'h0000_0000, 32'h0000_0000, 32'h0000_8000, 32'hFFFF_0000,
                                 32'h0005_0000, 32'h0002_0000, 32'h0001_0000};
        logic [31:0] vq [11] = '{32'h0003_0000, 32'h0000_5555, 32'hFFFF_AAAB, 32'hFFFC_8000,
                                 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                                 32'h0000_0000, 32'h0000_0000, 32'h8000_0000};
        logic        vz [11] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
        logic        vo [11] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
        logic [31:0] q;
        logic        dz, ov;
        int          lat;
        for (int i = 0; i < 11; i++) begin
            run_op(va[i], vb[i], (i == 0) ? 10 : 0, q, dz, ov, lat);
            checks++;
            if (q !== vq[i] || dz !== vz[i] || ov !== vo[i]) begin
                errors++;
                $display("FAIL directed %0d a=%h b=%h: q=%h dz=%b ovf=%b required q=%h dz=%b ovf=%b",
                         i, va[i], vb[i], q, dz, ov, vq[i], vz[i], vo[i]);
            end
            checks++;
            if (lat !== LAT) begin
                errors++;
                $display("FAIL latency %0d: %0d cycles, required %0d", i, lat, LAT);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, q, eq;
        logic        dz, ov, ez, eo;
        int          lat, mode;
        for (int i = 0; i < 30; i++) begin
            mode = int'($urandom_range(0, 4));
            a = $urandom;
            b = $urandom;
            case (mode)
                0: b = 32'h0;
                1: a = 32'($signed(a) >>> 8);
                2: a = a[0] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                3: begin
                    b = 32'($urandom_range(1, 32'h0003_0000));
                    if (a[1]) b = -b;
                end
                default: ;
            endcase
            ref_div(a, b, eq, ez, eo);
            run_op(a, b, int'($urandom_range(0, 3)), q, dz, ov, lat);
            checks++;
            if (q !== eq || dz !== ez || ov !== eo || lat !== LAT) begin
                errors++;
                $display("FAIL random %0d a=%h b=%h: q=%h dz=%b ovf=%b lat=%0d required q=%h dz=%b ovf=%b lat=%0d",
                         i, a, b, q, dz, ov, lat, eq, ez, eo, LAT);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q  [$];
        logic        exp_dz [$];
        logic        exp_ov [$];
        int          acc [$];
        logic [31:0] eq, sq;
        logic        ez, eo, sz, so, rdy_s, val_s;
        int          cyc, nres;
        cyc = 0; nres = 0;
        bus.out_ready = 1'b1;
        bus.a = $urandom; bus.b = 32'($urandom_range(1, 32'h0010_0000));
        ref_div(bus.a, bus.b, eq, ez, eo);
        exp_q.push_back(eq); exp_dz.push_back(ez); exp_ov.push_back(eo);
        bus.in_valid = 1'b1;
        while (nres < 3 && cyc < 4 * TMO) begin
            rdy_s = bus.in_ready; val_s = bus.out_valid;
            sq = bus.q; sz = bus.div_zero; so = bus.ovf;
            @(posedge clk); #1;
            cyc++;
            if (val_s === 1'b1) begin
                eq = exp_q.pop_front(); ez = exp_dz.pop_front(); eo = exp_ov.pop_front();
                nres++;
                checks++;
                if (sq !== eq || sz !== ez || so !== eo) begin
                    errors++;
                    $display("FAIL b2b result %0d: q=%h dz=%b ovf=%b required q=%h dz=%b ovf=%b",
                             nres, sq, sz, so, eq, ez, eo);
                end
            end
            if (rdy_s === 1'b1 && bus.in_valid === 1'b1) begin
                acc.push_back(cyc);
                if (acc.size() < 3) begin
                    bus.a = $urandom; bus.b = $urandom;
                    ref_div(bus.a, bus.b, eq, ez, eo);
                    exp_q.push_back(eq); exp_dz.push_back(ez); exp_ov.push_back(eo);
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (nres != 3 || acc.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: results=%0d accepts=%0d required 3 3", nres, acc.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (acc[i] - acc[i-1] != PERIOD) begin
                    errors++;
                    $display("FAIL b2b_period %0d: %0d cycles, required %0d", i, acc[i] - acc[i-1], PERIOD);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midrun();
        logic [31:0] q;
        logic        dz, ov;
        int          lat, w;
        bit          bad;
        w = 0;
        bus.a = 32'h0006_0000; bus.b = 32'h0002_0000; bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && w < TMO) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        // in_valid alongside reset must not start an operation
        rst = 1'b1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: in_ready=%b out_valid=%b required 1 0", bus.in_ready, bus.out_valid);
        end
        bad = 1'b0;
        for (int i = 0; i < N + 5; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL midrun_discard: out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
        end
        run_op(32'h0009_0000, 32'hFFFD_0000, 0, q, dz, ov, lat);
        checks++;
        if (q !== 32'hFFFD_0000 || dz !== 1'b0 || ov !== 1'b0 || lat !== LAT) begin
            errors++;
            $display("FAIL post_reset_op: q=%h dz=%b ovf=%b lat=%0d required q=fffd0000 dz=0 ovf=0 lat=%0d",
                     q, dz, ov, lat, LAT);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
